// File: rtl/filter_stream_tx_if.sv
// Pixel/coefficient stream from the frame source into the image filter input port.
// tx_valid marks a word this cycle; there is no ready: the filter consumes every valid word.
interface filter_stream_tx_if #(
    parameter int DATA_BIT   = 15,
    parameter int DATA_IDBIT = 2
) ();
    logic                  tx_valid;
    logic [DATA_IDBIT-1:0] tx_id;
    logic [DATA_BIT-1:0]   tx_data;

    modport master (output tx_valid, output tx_id, output tx_data);
    modport slave  (input  tx_valid, input  tx_id, input  tx_data);
endinterface

// File: rtl/filter_stream_tx.sv
// Frame source for the image filter: optional coefficient burst, one idle gap,
// a gapless raster pixel frame, then a fixed drain interval ending in a done pulse.
module filter_stream_tx #(
    parameter int DATA_BIT     = 15,
    parameter int DATA_IDBIT   = 2,
    parameter int ROW_WIDTH    = 512,
    parameter int COL_WIDTH    = 512,
    parameter int MASK_WIDTH   = 7,
    parameter int CF_ADDR_BIT  = 6,
    parameter int PIX_ADDR_BIT = 18,
    parameter int DRAIN_CYCLES = 2048
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    load_cf,
    output logic                    busy,
    output logic                    done,
    output logic                    cf_rd_en,
    output logic [CF_ADDR_BIT-1:0]  cf_rd_addr,
    input  logic [DATA_BIT-1:0]     cf_rd_data,
    output logic                    pix_rd_en,
    output logic [PIX_ADDR_BIT-1:0] pix_rd_addr,
    input  logic [DATA_BIT-1:0]     pix_rd_data,
    filter_stream_tx_if.master      tx_if,
    output logic [2:0]              o_dbg_state
);
    localparam int NCF       = MASK_WIDTH * MASK_WIDTH;
    localparam int NPIX      = ROW_WIDTH * COL_WIDTH;
    localparam int DRAIN_BIT = $clog2(DRAIN_CYCLES + 2);

    localparam logic [CF_ADDR_BIT-1:0]  CF_LAST    = CF_ADDR_BIT'(NCF - 1);
    localparam logic [PIX_ADDR_BIT-1:0] PIX_LAST   = PIX_ADDR_BIT'(NPIX - 1);
    // Drain counter is 0 in the cycle of the last pixel output, so done lands on DRAIN_CYCLES+1.
    localparam logic [DRAIN_BIT-1:0]    DRAIN_LAST = DRAIN_BIT'(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CF    = 3'd1,
        S_GAP   = 3'd2,
        S_PIX   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CF_ADDR_BIT-1:0]  r_cf_addr;
    logic [PIX_ADDR_BIT-1:0] r_pix_addr;
    logic [DRAIN_BIT-1:0]    r_drain_cnt;
    logic                    r_tx_valid;
    logic                    r_tx_is_cf;
    logic                    w_cf_last;
    logic                    w_pix_last;
    logic                    w_drain_last;

    assign w_cf_last    = (r_cf_addr == CF_LAST);
    assign w_pix_last   = (r_pix_addr == PIX_LAST);
    assign w_drain_last = (r_drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        cf_rd_en     = 1'b0;
        pix_rd_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = load_cf ? S_CF : S_PIX;
                end
            end
            S_CF: begin
                cf_rd_en = 1'b1;
                if (w_cf_last) begin
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                w_state_next = S_PIX;
            end
            S_PIX: begin
                pix_rd_en = 1'b1;
                if (w_pix_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_last) begin
                    done         = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Address counters restart on phase entry and hold the last issued address afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cf_addr   <= '0;
            r_pix_addr  <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_state_next == S_CF && r_state != S_CF) begin
                r_cf_addr <= '0;
            end else if (cf_rd_en && !w_cf_last) begin
                r_cf_addr <= r_cf_addr + CF_ADDR_BIT'(1);
            end

            if (w_state_next == S_PIX && r_state != S_PIX) begin
                r_pix_addr <= '0;
            end else if (pix_rd_en && !w_pix_last) begin
                r_pix_addr <= r_pix_addr + PIX_ADDR_BIT'(1);
            end

            if (r_state != S_DRAIN) begin
                r_drain_cnt <= '0;
            end else if (!w_drain_last) begin
                r_drain_cnt <= r_drain_cnt + DRAIN_BIT'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_valid <= 1'b0;
            r_tx_is_cf <= 1'b0;
        end else begin
            r_tx_valid <= cf_rd_en | pix_rd_en;
            r_tx_is_cf <= cf_rd_en;
        end
    end

    // Memory data arrives one cycle after the strobe, aligned with the registered valid/type.
    assign tx_if.tx_valid = r_tx_valid;
    assign tx_if.tx_id    = {{(DATA_IDBIT-1){1'b0}}, r_tx_is_cf};
    assign tx_if.tx_data  = !r_tx_valid ? '0 : (r_tx_is_cf ? cf_rd_data : pix_rd_data);

    assign cf_rd_addr  = r_cf_addr;
    assign pix_rd_addr = r_pix_addr;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_filter_stream_tx.sv
// Directed bench for filter_stream_tx: reset, framed streams with and without
// coefficients, ignored start while busy, and reset in the middle of a frame.
module tb_filter_stream_tx;
    localparam int DATA_BIT     = 15;
    localparam int DATA_IDBIT   = 2;
    localparam int ROW_WIDTH    = 8;
    localparam int COL_WIDTH    = 6;
    localparam int MASK_WIDTH   = 3;
    localparam int CF_ADDR_BIT  = 6;
    localparam int PIX_ADDR_BIT = 18;
    localparam int DRAIN        = 10;
    localparam int NCF          = MASK_WIDTH * MASK_WIDTH;
    localparam int NPIX         = ROW_WIDTH * COL_WIDTH;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic                    load_cf;
    logic                    busy;
    logic                    done;
    logic                    cf_rd_en;
    logic [CF_ADDR_BIT-1:0]  cf_rd_addr;
    logic [DATA_BIT-1:0]     cf_rd_data;
    logic                    pix_rd_en;
    logic [PIX_ADDR_BIT-1:0] pix_rd_addr;
    logic [DATA_BIT-1:0]     pix_rd_data;
    logic [2:0]              dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    filter_stream_tx_if #(.DATA_BIT(DATA_BIT), .DATA_IDBIT(DATA_IDBIT)) u_if ();

    filter_stream_tx #(
        .DATA_BIT(DATA_BIT), .DATA_IDBIT(DATA_IDBIT), .ROW_WIDTH(ROW_WIDTH),
        .COL_WIDTH(COL_WIDTH), .MASK_WIDTH(MASK_WIDTH), .CF_ADDR_BIT(CF_ADDR_BIT),
        .PIX_ADDR_BIT(PIX_ADDR_BIT), .DRAIN_CYCLES(DRAIN)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .load_cf(load_cf),
        .busy(busy), .done(done),
        .cf_rd_en(cf_rd_en), .cf_rd_addr(cf_rd_addr), .cf_rd_data(cf_rd_data),
        .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
        .tx_if(u_if), .o_dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed one-cycle-latency memories; idle value is a marker that must never leak out.
    always @(posedge clk) begin
        cf_rd_data  <= cf_rd_en  ? DATA_BIT'(int'(cf_rd_addr) + 100)  : DATA_BIT'(16'h7fff);
        pix_rd_data <= pix_rd_en ? DATA_BIT'(int'(pix_rd_addr) + 200) : DATA_BIT'(16'h7fff);
    end

    // Cycle 0 is the negedge where start is raised; each later negedge samples cycle k.
    task automatic run_frame(input bit lcf, input int pulse_at, input int reset_at,
                             output int n_done);
        int pbase, last_out, done_cyc, end_cyc;
        logic e_cf, e_pix, e_cfo, e_pixo;
        logic [DATA_BIT-1:0] e_data;
        logic [21:0] act, exp;
        pbase    = lcf ? NCF + 2 : 1;
        last_out = pbase + NPIX;
        done_cyc = last_out + DRAIN + 1;
        end_cyc  = (reset_at > 0) ? reset_at : done_cyc + 1;
        n_done   = 0;
        @(negedge clk);
        start   = 1'b1;
        load_cf = lcf;
        for (int k = 1; k <= end_cyc; k++) begin
            @(negedge clk);
            start   = (k == pulse_at);
            load_cf = ~lcf;
            e_cf   = lcf && k >= 1 && k <= NCF;
            e_pix  = k >= pbase && k < pbase + NPIX;
            e_cfo  = lcf && k >= 2 && k <= NCF + 1;
            e_pixo = k >= pbase + 1 && k <= last_out;
            e_data = e_cfo ? DATA_BIT'(100 + k - 2) :
                     (e_pixo ? DATA_BIT'(200 + k - pbase - 1) : '0);
            exp = {k <= done_cyc, k == done_cyc, e_cf, e_pix, e_cfo | e_pixo,
                   1'b0, e_cfo, e_data};
            act = {busy, done, cf_rd_en, pix_rd_en, u_if.tx_valid, u_if.tx_id, u_if.tx_data};
            n_checks++;
            if (act !== exp) begin
                n_errors++;
                $display("FAIL frame_cyc%0d got busy/done/cf_en/pix_en/valid=%b id=%0d data=%0d expected busy/done/cf_en/pix_en/valid=%b id=%0d data=%0d",
                         k, act[21:17], act[16:15], act[14:0], exp[21:17], exp[16:15], exp[14:0]);
            end
            if (e_cf) begin
                n_checks++;
                if (cf_rd_addr !== CF_ADDR_BIT'(k - 1)) begin
                    n_errors++;
                    $display("FAIL cf_addr cyc%0d got %0d expected %0d", k, cf_rd_addr, k - 1);
                end
            end
            if (e_pix) begin
                n_checks++;
                if (pix_rd_addr !== PIX_ADDR_BIT'(k - pbase)) begin
                    n_errors++;
                    $display("FAIL pix_addr cyc%0d got %0d expected %0d", k, pix_rd_addr, k - pbase);
                end
            end
            if (k == done_cyc + 1) begin
                n_checks++;
                if (pix_rd_addr !== PIX_ADDR_BIT'(NPIX - 1)) begin
                    n_errors++;
                    $display("FAIL pix_addr_hold got %0d expected %0d", pix_rd_addr, NPIX - 1);
                end
            end
            if (done === 1'b1) n_done++;
            if (k == reset_at) begin
                reset = 1'b0;
                start = 1'b0;
            end
        end
        load_cf = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        start   = 1'b1;
        load_cf = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done, cf_rd_en, cf_rd_addr, pix_rd_en, pix_rd_addr, u_if.tx_valid,
                 u_if.tx_id, u_if.tx_data, dbg_state} !== '0) begin
                n_errors++;
                $display("FAIL reset_hold cyc%0d got busy=%b done=%b cf_en=%b pix_en=%b valid=%b data=%0d expected all zero",
                         i, busy, done, cf_rd_en, pix_rd_en, u_if.tx_valid, u_if.tx_data);
            end
        end
        reset   = 1'b1;
        start   = 1'b0;
        load_cf = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dbg_state !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_release got busy=%b state=%0d expected busy=0 state=0", busy, dbg_state);
        end
    endtask

    task automatic test_frame_cf();
        int nd;
        run_frame(1'b1, 0, 0, nd);
        n_checks++;
        if (nd != 1) begin
            n_errors++;
            $display("FAIL frame_cf_done_count got %0d expected 1", nd);
        end
    endtask

    task automatic test_frame_nocf();
        int nd;
        run_frame(1'b0, 0, 0, nd);
        n_checks++;
        if (nd != 1) begin
            n_errors++;
            $display("FAIL frame_nocf_done_count got %0d expected 1", nd);
        end
    endtask

    task automatic test_start_ignored();
        int nd;
        run_frame(1'b0, 20, 0, nd);
        n_checks++;
        if (nd != 1) begin
            n_errors++;
            $display("FAIL start_ignored_done_count got %0d expected 1", nd);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy, cf_rd_en, pix_rd_en} !== 3'b101 || pix_rd_addr !== '0) begin
            n_errors++;
            $display("FAIL restart_at_61 got busy/cf_en/pix_en=%b addr=%0d expected 101 addr=0",
                     {busy, cf_rd_en, pix_rd_en}, pix_rd_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int nd;
        run_frame(1'b1, 0, 30, nd);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done, cf_rd_en, cf_rd_addr, pix_rd_en, pix_rd_addr, u_if.tx_valid,
                 u_if.tx_id, u_if.tx_data, dbg_state} !== '0) begin
                n_errors++;
                $display("FAIL mid_reset cyc%0d got busy=%b cf_en=%b pix_en=%b pix_addr=%0d valid=%b data=%0d expected all zero",
                         31 + i, busy, cf_rd_en, pix_rd_en, pix_rd_addr, u_if.tx_valid, u_if.tx_data);
            end
            reset = 1'b1;
        end
        run_frame(1'b1, 0, 0, nd);
        n_checks++;
        if (nd != 1) begin
            n_errors++;
            $display("FAIL replay_done_count got %0d expected 1", nd);
        end
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        load_cf = 1'b0;
        test_reset();
        test_frame_cf();
        test_frame_nocf();
        test_start_ignored();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/filter_stream_tx.md
# filter_stream_tx

Frame source for the image filter's input port: streams one coefficient set (optional) and one full image frame into the filter's `data_in_valid` / `data_id` / `data_in` interface.
- Reads coefficients and pixels from two fixed-latency read ports, one for each.
- Enforces the framing the filter requires:
  - coefficient words contiguous;
  - exactly one idle cycle before pixels;
  - pixel words gapless for the whole frame;
  - a drain interval before the next frame.
- Sits between the frame/coefficient memories and the filter's control unit.

## Interface
- `DATA_BIT`, 15, data word width
- `DATA_IDBIT`, 2, data ID width
- `ROW_WIDTH`, 512, pixels per row
- `COL_WIDTH`, 512, rows per frame
- `MASK_WIDTH`, 7, mask size; coefficient count = `MASK_WIDTH*MASK_WIDTH`
- `CF_ADDR_BIT`, 6, coefficient address width
- `PIX_ADDR_BIT`, 18, pixel address width
- `DRAIN_CYCLES`, 2048, idle cycles after the last pixel before `done`
- `clk` in 1 — single clock; all logic on rising edge
- `reset` in 1 — synchronous, active-low (`reset==0` resets on the clock edge)
- `start` in 1 — frame request, sampled in IDLE only
- `load_cf` in 1 — sampled with `start`; 1 = send coefficients before the frame
- `busy` out 1 — high from the cycle after an accepted `start` until the cycle after `done`
- `done` out 1 — one-cycle pulse at the end of drain
- `cf_rd_en` out 1 — coefficient read strobe
- `cf_rd_addr` out `CF_ADDR_BIT` — coefficient address
- `cf_rd_data` in `DATA_BIT` — coefficient data, valid 1 cycle after `cf_rd_en`
- `pix_rd_en` out 1 — pixel read strobe
- `pix_rd_addr` out `PIX_ADDR_BIT` — raster-order pixel address
- `pix_rd_data` in `DATA_BIT` — pixel data, valid 1 cycle after `pix_rd_en`
- `tx_valid` out 1 — drives filter `data_in_valid`
- `tx_id` out `DATA_IDBIT` — drives filter `data_id`: 1 = coefficient, 0 = pixel (zero-extended)
- `tx_data` out `DATA_BIT` — drives filter `data_in`

## Operation
- States: IDLE, CF, GAP, PIX, DRAIN.
- IDLE:
  - all read strobes 0; `busy`=0.
  - On `start`=1: go to CF if `load_cf`=1, else PIX.
- CF: issue `NCF=MASK_WIDTH*MASK_WIDTH` consecutive reads, addr 0..NCF-1; after the last read go to GAP.
- GAP: exactly one cycle with no read; go to PIX.
- PIX:
  - issue `NPIX=ROW_WIDTH*COL_WIDTH` consecutive reads, addr 0..NPIX-1 in raster order.
  - never stalls, since any gap drops the filter into its EMPTY state.
  - After the last read go to DRAIN.
- DRAIN:
  - count `DRAIN_CYCLES` cycles measured from the cycle after the last pixel output.
  - then assert `done` for one cycle; return to IDLE the following cycle.
- Output stage: registered.
  - `tx_valid`/`tx_id` are the 1-cycle-delayed strobe/type.
  - `tx_data` is the read data returned that cycle.
  - `tx_data`=0 and `tx_id`=0 whenever `tx_valid`=0.
- Address counters: reset to 0 on entry to CF/PIX; no wrap during a phase; the final address is the last one issued.
- `start` while `busy`=1: ignored, not queued. `load_cf` is ignored outside the `start` sample.
- Reset mid-operation:
  - next cycle all outputs return to reset values; state IDLE.
  - In-flight read data is discarded (no `tx_valid`).
- Reset values: `busy`=0, `done`=0, `cf_rd_en`=0, `cf_rd_addr`=0, `pix_rd_en`=0, `pix_rd_addr`=0, `tx_valid`=0, `tx_id`=0, `tx_data`=0.

## Timing
Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- With `load_cf`=1:
  - `cf_rd_en` cycles 1..NCF; `tx_valid`/`tx_id`=1 cycles 2..NCF+1.
  - Cycle NCF+2: `tx_valid`=0 (the gap).
  - `pix_rd_en` cycles NCF+2..NCF+NPIX+1; pixel outputs cycles NCF+3..NCF+NPIX+2.
- With `load_cf`=0:
  - `pix_rd_en` cycles 1..NPIX; pixel outputs cycles 2..NPIX+1.
- Let L be the cycle of the last pixel output:
  - `done`=1 at cycle L+DRAIN_CYCLES+1.
  - `busy` high cycles 1..L+DRAIN_CYCLES+1, low from L+DRAIN_CYCLES+2.
- Earliest next `start` acceptance: cycle L+DRAIN_CYCLES+2.
- Read-to-output latency: exactly 1 cycle. Strobes are never asserted in the same cycle on both ports.

## Test plan
Bench parameters: `ROW_WIDTH`=8, `COL_WIDTH`=6, `MASK_WIDTH`=3, `DRAIN_CYCLES`=10; memories return data = addr+100 (coefficients) and addr+200 (pixels).
- Reset: hold `reset`=0 for 3 cycles with `start`=1 -> all outputs 0 throughout; no reads.
- Full frame, `load_cf`=1, `start` at cycle 0:
  - `tx_id`=1, data 100..108 in cycles 2..10.
  - `tx_valid`=0 at cycle 11.
  - `tx_id`=0, data 200..247 gapless in cycles 12..59.
  - `done` at 70; `busy` low at 71.
- Frame without coefficients, `load_cf`=0: first `pix_rd_en` at cycle 1; data 200..247 in cycles 2..49; `done` at 60; no `cf_rd_en` ever.
- `start` pulsed at cycle 20 during the frame above -> ignored; exactly one `done`; a `start` at cycle 61 is accepted (`pix_rd_en` at 62).
- Reset asserted at cycle 30 of a `load_cf`=1 frame -> cycle 31 all outputs 0; no `tx_valid` from in-flight data; a new `start` after release replays the frame from coefficient addr 0.
